// File: rtl/knn_batch_ctrl.sv
// rtl/knn_batch_ctrl.sv - batch sequencer for knn_top: load, start, watchdog wait, result report
module knn_batch_ctrl #(
    parameter int IDX_W          = 10,
    parameter int LABEL_W        = 4,
    parameter int TMO_W          = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               batch_start,
    input  logic [IDX_W-1:0]   batch_base,
    input  logic [IDX_W:0]     batch_count,
    output logic               batch_busy,
    output logic               batch_done,
    output logic [IDX_W:0]     correct_count,
    output logic [IDX_W:0]     timeout_count,
    output logic               load_req,
    output logic [IDX_W-1:0]   load_idx,
    input  logic               load_ack,
    input  logic [LABEL_W-1:0] load_label,
    output logic               knn_start,
    input  logic               knn_done,
    input  logic               knn_idle,
    input  logic [LABEL_W-1:0] knn_label,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDX_W-1:0]   res_idx,
    output logic [LABEL_W-1:0] res_pred,
    output logic               res_match,
    output logic               res_timeout
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [2:0]         state_q, state_d;
    logic [IDX_W:0]     count_q, count_d;
    logic [IDX_W:0]     cur_q, cur_d;
    logic [LABEL_W-1:0] expected_q, expected_d;
    logic [TMO_W-1:0]   timer_q, timer_d;
    logic [IDX_W:0]     correct_q, correct_d;
    logic [IDX_W:0]     timeouts_q, timeouts_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load_req_q, load_req_d;
    logic [IDX_W-1:0]   load_idx_q, load_idx_d;
    logic               knn_start_q, knn_start_d;
    logic               res_valid_q, res_valid_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic [LABEL_W-1:0] res_pred_q, res_pred_d;
    logic               res_match_q, res_match_d;
    logic               res_timeout_q, res_timeout_d;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        cur_d         = cur_q;
        expected_d    = expected_q;
        timer_d       = timer_q;
        correct_d     = correct_q;
        timeouts_d    = timeouts_q;
        done_d        = 1'b0;
        knn_start_d   = 1'b0;
        load_idx_d    = load_idx_q;
        res_idx_d     = res_idx_q;
        res_pred_d    = res_pred_q;
        res_match_d   = res_match_q;
        res_timeout_d = res_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (batch_start) begin
                    count_d    = batch_count;
                    cur_d      = '0;
                    correct_d  = '0;
                    timeouts_d = '0;
                    load_idx_d = batch_base;
                    if (batch_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                // Start is decided here so knn_start can be a flop that rises with START.
                if (load_ack) begin
                    expected_d  = load_label;
                    state_d     = S_START;
                    knn_start_d = knn_idle;
                end
            end
            S_START: begin
                if (knn_start_q) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else if (knn_idle) begin
                    knn_start_d = 1'b1;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TMO_ONE;
                if (knn_done) begin
                    state_d       = S_REPORT;
                    res_idx_d     = load_idx_q;
                    res_pred_d    = knn_label;
                    res_match_d   = (knn_label == expected_q);
                    res_timeout_d = 1'b0;
                end else if (timer_q == TMO_LAST) begin
                    state_d       = S_REPORT;
                    res_idx_d     = load_idx_q;
                    res_pred_d    = '1;
                    res_match_d   = 1'b0;
                    res_timeout_d = 1'b1;
                    timeouts_d    = timeouts_q + CNT_ONE;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    correct_d = correct_q + {{IDX_W{1'b0}}, res_match_q};
                    if (cur_q + CNT_ONE == count_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cur_d      = cur_q + CNT_ONE;
                        load_idx_d = load_idx_q + IDX_ONE;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        load_req_d  = (state_d == S_LOAD);
        res_valid_d = (state_d == S_REPORT);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            cur_q         <= '0;
            expected_q    <= '0;
            timer_q       <= '0;
            correct_q     <= '0;
            timeouts_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            load_req_q    <= 1'b0;
            load_idx_q    <= '0;
            knn_start_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_idx_q     <= '0;
            res_pred_q    <= '0;
            res_match_q   <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            cur_q         <= cur_d;
            expected_q    <= expected_d;
            timer_q       <= timer_d;
            correct_q     <= correct_d;
            timeouts_q    <= timeouts_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            load_req_q    <= load_req_d;
            load_idx_q    <= load_idx_d;
            knn_start_q   <= knn_start_d;
            res_valid_q   <= res_valid_d;
            res_idx_q     <= res_idx_d;
            res_pred_q    <= res_pred_d;
            res_match_q   <= res_match_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign batch_busy    = busy_q;
    assign batch_done    = done_q;
    assign correct_count = correct_q;
    assign timeout_count = timeouts_q;
    assign load_req      = load_req_q;
    assign load_idx      = load_idx_q;
    assign knn_start     = knn_start_q;
    assign res_valid     = res_valid_q;
    assign res_idx       = res_idx_q;
    assign res_pred      = res_pred_q;
    assign res_match     = res_match_q;
    assign res_timeout   = res_timeout_q;

endmodule
